// File: rtl/rf_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_arbiter_pkg
// Description : Shared constants and types for the register-file write-back
//               arbiter and its aux FIFO.
// Contents    : REG_ADDR_W, DATA_W, NUM_REGS; aux_entry_t (dest + value).
// Revision    : 1.0 - initial release
// ============================================================================
package rf_write_arbiter_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 16;

  // One queued auxiliary write: destination register and its data.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     value;
  } aux_entry_t;

endpackage : rf_write_arbiter_pkg
`default_nettype wire

// File: rtl/rf_write_arbiter_aux_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : aux_wb_fifo
// Description : Synchronous FIFO buffering auxiliary write-back requests.
//               Also exposes per-slot valid and dest vectors so the parent
//               can build the register busy map without walking pointers.
// Ports       : clk, rst          - clock, sync active-high reset
//               i_push, i_wdata   - enqueue (ignored when full)
//               i_pop, o_rdata    - dequeue (ignored when empty), head data
//               o_full, o_empty   - occupancy flags
//               o_entry_valid     - slot i currently holds a queued entry
//               o_entry_dest      - dest field of slot i
// Revision    : 1.0 - initial release
// ============================================================================
module aux_wb_fifo
  import rf_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_push,
  input  aux_entry_t                           i_wdata,
  input  logic                                 i_pop,
  output aux_entry_t                           o_rdata,
  output logic                                 o_full,
  output logic                                 o_empty,
  output logic [DEPTH-1:0]                     o_entry_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]     o_entry_dest
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  aux_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: stale slots are masked by o_entry_valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // A slot is live when its distance from the read pointer (mod DEPTH)
  // is below the occupancy count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_scan
    logic [PTR_W-1:0] w_off;
    assign w_off             = PTR_W'(gi) - r_rd_ptr;
    assign o_entry_valid[gi] = ({1'b0, w_off} < r_count);
    assign o_entry_dest[gi]  = r_mem[gi].dest;
  end

endmodule : aux_wb_fifo
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_arbiter
// Description : Shares the register file's single write port between the
//               pipeline WB stage (always wins) and a FIFO-buffered
//               auxiliary source. Outputs to the RF are registered.
// Ports       : clk, rst                        - clock, sync active-high reset
//               i_wb_en/i_wb_dest/i_wb_value    - pipeline write-back
//               i_aux_valid/o_aux_ready         - aux handshake
//               i_aux_dest/i_aux_value          - aux write payload
//               o_rf_we/o_rf_dest/o_rf_value    - register-file write port
//               o_busy                          - regs with pending aux write
//               o_stall_req                     - aux head starving, freeze FE
// Revision    : 1.0 - initial release
// ============================================================================
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wb_en,
  input  logic [REG_ADDR_W-1:0] i_wb_dest,
  input  logic [DATA_W-1:0]     i_wb_value,
  input  logic                  i_aux_valid,
  output logic                  o_aux_ready,
  input  logic [REG_ADDR_W-1:0] i_aux_dest,
  input  logic [DATA_W-1:0]     i_aux_value,
  output logic                  o_rf_we,
  output logic [REG_ADDR_W-1:0] o_rf_dest,
  output logic [DATA_W-1:0]     o_rf_value,
  output logic [NUM_REGS-1:0]   o_busy,
  output logic                  o_stall_req
);

  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

  aux_entry_t                       w_head;
  aux_entry_t                       w_wdata;
  logic                             w_full;
  logic                             w_empty;
  logic                             w_push;
  logic                             w_pop;
  logic [DEPTH-1:0]                 w_ent_valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] w_ent_dest;
  logic [NUM_REGS-1:0]              w_busy;
  logic [WAIT_W-1:0]                w_wait_nxt;

  logic                  r_rf_we;
  logic [REG_ADDR_W-1:0] r_rf_dest;
  logic [DATA_W-1:0]     r_rf_value;
  logic                  r_aux_src;
  logic [WAIT_W-1:0]     r_wait;
  logic                  r_stall_req;

  // Ready is held low during reset so nothing is accepted into a FIFO
  // that is being cleared.
  assign o_aux_ready   = !rst && !w_full;
  assign w_push        = i_aux_valid && o_aux_ready;
  // Aux only drains in cycles the pipeline leaves the port free.
  assign w_pop         = !rst && !i_wb_en && !w_empty;
  assign w_wdata.dest  = i_aux_dest;
  assign w_wdata.value = i_aux_value;

  aux_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .i_push        (w_push),
    .i_wdata       (w_wdata),
    .i_pop         (w_pop),
    .o_rdata       (w_head),
    .o_full        (w_full),
    .o_empty       (w_empty),
    .o_entry_valid (w_ent_valid),
    .o_entry_dest  (w_ent_dest)
  );

  // Output register. dest/value hold on idle cycles; only rf_we drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rf_we    <= 1'b0;
      r_rf_dest  <= '0;
      r_rf_value <= '0;
      r_aux_src  <= 1'b0;
    end else if (i_wb_en) begin
      r_rf_we    <= 1'b1;
      r_rf_dest  <= i_wb_dest;
      r_rf_value <= i_wb_value;
      r_aux_src  <= 1'b0;
    end else if (!w_empty) begin
      r_rf_we    <= 1'b1;
      r_rf_dest  <= w_head.dest;
      r_rf_value <= w_head.value;
      r_aux_src  <= 1'b1;
    end else begin
      r_rf_we    <= 1'b0;
      r_aux_src  <= 1'b0;
    end
  end

  // A register stays busy until its last aux write has left the output
  // register, so the hazard unit cannot read it before the RF commits it.
  always_comb begin
    w_busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ent_valid[i]) w_busy[w_ent_dest[i]] = 1'b1;
    end
    if (r_rf_we && r_aux_src) w_busy[r_rf_dest] = 1'b1;
  end

  // Wait counter: counts cycles the head is blocked by pipeline writes.
  // A non-empty, non-popping FIFO implies wb_en is high here.
  always_comb begin
    w_wait_nxt = r_wait;
    if (w_empty || w_pop) begin
      w_wait_nxt = '0;
    end else if (i_wb_en && (r_wait != WAIT_W'(STARVE_LIMIT))) begin
      w_wait_nxt = r_wait + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait      <= '0;
      r_stall_req <= 1'b0;
    end else begin
      r_wait      <= w_wait_nxt;
      r_stall_req <= (w_wait_nxt == WAIT_W'(STARVE_LIMIT));
    end
  end

  assign o_rf_we     = r_rf_we;
  assign o_rf_dest   = r_rf_dest;
  assign o_rf_value  = r_rf_value;
  assign o_busy      = w_busy;
  assign o_stall_req = r_stall_req;

endmodule : rf_write_arbiter
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_write_arbiter
// Description : Directed self-checking bench for rf_write_arbiter. A queue
//               holds the aux entries the bench expects to see written, in
//               order; a small reference model predicts every RF output,
//               busy map, ready and stall value after each clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;
  import rf_write_arbiter_pkg::*;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic                  clk;
  logic                  rst;
  logic                  wb_en;
  logic [REG_ADDR_W-1:0] wb_dest;
  logic [DATA_W-1:0]     wb_value;
  logic                  aux_valid;
  logic                  aux_ready;
  logic [REG_ADDR_W-1:0] aux_dest;
  logic [DATA_W-1:0]     aux_value;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_dest;
  logic [DATA_W-1:0]     rf_value;
  logic [NUM_REGS-1:0]   busy;
  logic                  stall_req;

  rf_write_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_wb_en     (wb_en),
    .i_wb_dest   (wb_dest),
    .i_wb_value  (wb_value),
    .i_aux_valid (aux_valid),
    .o_aux_ready (aux_ready),
    .i_aux_dest  (aux_dest),
    .i_aux_value (aux_value),
    .o_rf_we     (rf_we),
    .o_rf_dest   (rf_dest),
    .o_rf_value  (rf_value),
    .o_busy      (busy),
    .o_stall_req (stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state
  aux_entry_t            sb_q[$];
  logic                  m_we;
  logic [REG_ADDR_W-1:0] m_dest;
  logic [DATA_W-1:0]     m_val;
  logic                  m_aux;
  int                    m_wait;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, update the model, then compare all outputs.
  task automatic tick(input string tag);
    bit                  pre_empty;
    bit                  acc;
    bit                  popped;
    aux_entry_t          h;
    aux_entry_t          n;
    logic [NUM_REGS-1:0] eb;
    pre_empty = (sb_q.size() == 0);
    acc       = aux_valid && !rst && (sb_q.size() < DEPTH);
    popped    = 1'b0;
    n.dest    = aux_dest;
    n.value   = aux_value;
    @(posedge clk);
    if (rst) begin
      sb_q.delete();
      m_we = 1'b0; m_dest = '0; m_val = '0; m_aux = 1'b0; m_wait = 0;
    end else begin
      if (wb_en) begin
        m_we = 1'b1; m_dest = wb_dest; m_val = wb_value; m_aux = 1'b0;
      end else if (!pre_empty) begin
        h = sb_q.pop_front();
        m_we = 1'b1; m_dest = h.dest; m_val = h.value; m_aux = 1'b1;
        popped = 1'b1;
      end else begin
        m_we = 1'b0; m_aux = 1'b0;
      end
      if (pre_empty || popped) m_wait = 0;
      else if (wb_en && m_wait < STARVE_LIMIT) m_wait++;
      if (acc) sb_q.push_back(n);
    end
    #1;
    eb = '0;
    foreach (sb_q[i]) eb[sb_q[i].dest] = 1'b1;
    if (m_aux && m_we) eb[m_dest] = 1'b1;
    chk({tag, ".rf_we"},     32'(rf_we),     32'(m_we));
    chk({tag, ".rf_dest"},   32'(rf_dest),   32'(m_dest));
    chk({tag, ".rf_value"},  rf_value,       m_val);
    chk({tag, ".busy"},      32'(busy),      32'(eb));
    chk({tag, ".aux_ready"}, 32'(aux_ready), 32'(!rst && sb_q.size() < DEPTH));
    chk({tag, ".stall_req"}, 32'(stall_req), 32'(m_wait == STARVE_LIMIT));
  endtask

  initial begin
    logic [REG_ADDR_W-1:0] fill_dest [4];
    fill_dest[0] = 4'd3; fill_dest[1] = 4'd4; fill_dest[2] = 4'd5; fill_dest[3] = 4'd3;

    // Reset with aux_valid asserted
    rst = 1'b1; wb_en = 1'b0; wb_dest = '0; wb_value = '0;
    aux_valid = 1'b1; aux_dest = 4'd7; aux_value = 32'h77;
    tick("reset0");
    tick("reset1");
    chk("reset_ready_low", 32'(aux_ready), 32'd0);
    rst = 1'b0; aux_valid = 1'b0;
    #1;
    chk("post_reset_ready", 32'(aux_ready), 32'd1);

    // Pipeline only
    wb_en = 1'b1; wb_dest = 4'd1; wb_value = 32'h2;
    tick("pipe");
    chk("pipe_value", rf_value, 32'h2);
    wb_en = 1'b0;
    tick("pipe_idle");
    chk("pipe_idle_we", 32'(rf_we), 32'd0);

    // Aux path latency
    aux_valid = 1'b1; aux_dest = 4'd2; aux_value = 32'h4;
    tick("aux_push");
    aux_valid = 1'b0;
    chk("aux_busy2_set", 32'(busy[2]), 32'd1);
    tick("aux_out");
    chk("aux_out_value", rf_value, 32'h4);
    tick("aux_done");
    chk("aux_busy2_clr", 32'(busy[2]), 32'd0);

    // Priority and full
    wb_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wb_dest = 4'(8 + i); wb_value = 32'h100 + 32'(i);
      aux_valid = 1'b1; aux_dest = fill_dest[i]; aux_value = 32'h10 + 32'(i);
      tick("fill");
    end
    chk("full_ready_low", 32'(aux_ready), 32'd0);
    chk("full_busy", 32'(busy[5:3]), 32'h7);
    aux_dest = 4'd9; aux_value = 32'hDEAD;
    tick("full_no_push");
    aux_valid = 1'b0; wb_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick("drain");
      chk("drain_order", rf_value, 32'h10 + 32'(i));
      chk("drain_busy3", 32'(busy[3]), 32'd1);
    end
    tick("drain_end");
    chk("drain_busy3_clr", 32'(busy[3]), 32'd0);

    // Pop while full: the push attempted in the same cycle must be refused
    wb_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      aux_valid = 1'b1; aux_dest = 4'(i + 10); aux_value = 32'h200 + 32'(i);
      tick("refill");
    end
    wb_en = 1'b0; aux_dest = 4'd15; aux_value = 32'hBAD;
    tick("full_pop_push");
    aux_valid = 1'b0;

    // Mixed traffic, exercises pointer wrap and simultaneous push/pop
    for (int i = 0; i < 24; i++) begin
      wb_en     = 1'($urandom_range(0, 1));
      wb_dest   = 4'($urandom_range(0, 15));
      wb_value  = $urandom;
      aux_valid = 1'($urandom_range(0, 1));
      aux_dest  = 4'($urandom_range(0, 15));
      aux_value = $urandom;
      tick("mixed");
    end

    // Drain, bounded
    wb_en = 1'b0; aux_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick("flush");

    // Starvation
    wb_en = 1'b1; wb_dest = 4'd0; wb_value = 32'h55;
    aux_valid = 1'b1; aux_dest = 4'd6; aux_value = 32'h66;
    tick("starve_push");
    aux_valid = 1'b0;
    for (int i = 0; i < STARVE_LIMIT - 1; i++) tick("starve_wait");
    chk("starve_not_yet", 32'(stall_req), 32'd0);
    tick("starve_hit");
    chk("starve_stall", 32'(stall_req), 32'd1);
    tick("starve_sat");
    wb_en = 1'b0;
    tick("starve_release");
    chk("starve_release_stall", 32'(stall_req), 32'd0);
    chk("starve_release_value", rf_value, 32'h66);

    // Reset mid-queue
    wb_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      aux_valid = 1'b1; aux_dest = 4'(i + 1); aux_value = 32'hC0 + 32'(i);
      tick("mq_push");
    end
    aux_valid = 1'b0; rst = 1'b1;
    tick("mq_reset");
    chk("mq_busy_clr", 32'(busy), 32'd0);
    rst = 1'b0; wb_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick("mq_after");
      chk("mq_no_stale", 32'(rf_we), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_rf_write_arbiter
`default_nettype wire

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register file's single write-back port between two sources:
  - the pipeline WB stage, which always wins and never stalls;
  - an auxiliary multi-cycle source (multiplier / late load), which uses valid/ready and is buffered in a FIFO.
- Drives the register file's writeBackEn/destWB/valueWB inputs from registered outputs.
- Exports a per-register busy map to the hazard unit and a starvation stall request.

Parameters:
- DEPTH, 4, aux FIFO entries; power of two, minimum 2.
- STARVE_LIMIT, 8, consecutive cycles the FIFO head may wait before stall_req asserts.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- wb_en  in  1  pipeline write-back request; always accepted.
- wb_dest  in  4  pipeline destination register.
- wb_value  in  32  pipeline write data.
- aux_valid  in  1  aux request valid.
- aux_ready  out  1  aux request accepted this cycle when aux_valid && aux_ready.
- aux_dest  in  4  aux destination register.
- aux_value  in  32  aux write data.
- rf_we  out  1  to RegisterFile writeBackEn.
- rf_dest  out  4  to RegisterFile destWB.
- rf_value  out  32  to RegisterFile valueWB.
- busy  out  16  bit r set while an aux write to Rr is queued or in the output register.
- stall_req  out  1  to hazard unit: freeze front end so the pipeline WB slot empties.

Behaviour:
- Reset (rst=1 at an edge):
  - rf_we=0, rf_dest=0, rf_value=0.
  - FIFO count, pointers and wait counter cleared; stall_req=0; busy=0.
  - Queued aux entries are discarded, including mid-operation.
  - aux_ready=0 while rst=1.
- aux_ready = !full (combinational from count).
  - No push when full, even if a pop occurs the same cycle.
- Output register, updated every edge:
  - If wb_en: rf_we=1, rf_dest=wb_dest, rf_value=wb_value; FIFO untouched.
  - Else if FIFO not empty: pop head; rf_we=1, rf_dest/rf_value = head; mark the output as aux-sourced.
  - Else: rf_we=0; rf_dest/rf_value hold their last values.
- Latency:
  - Pipeline request at edge N appears on rf_* after edge N, so the RF writes at its next write edge.
  - No bypass from aux input to output. An aux request accepted at edge N is in the FIFO after N and can reach rf_* at the earliest after N+1.
- Ordering: aux entries are written strictly FIFO. Same-dest duplicates are allowed and written in order.
- Simultaneous push and pop: both take effect; count is unchanged.
- Pointer wrap: pointers wrap modulo DEPTH; full/empty come from a count of width log2(DEPTH)+1.
- busy[r] = 1 if any valid FIFO entry has dest r, OR the output register is aux-sourced with rf_we=1 and rf_dest=r.
  - busy is combinational from registered state.
  - It clears the cycle after the last such write leaves the output register.
- Hazard unit contract: it must not issue an instruction writing or reading Rr while busy[r]. The arbiter does not check WAW against pipeline writes.
- Wait counter:
  - Increments each cycle the FIFO is non-empty and wb_en=1 (head blocked).
  - Resets to 0 on any pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
  - stall_req = (wait counter == STARVE_LIMIT), registered; deasserts the cycle after a pop.

Decomposition:
- Shared package constants: REG_ADDR_W=4, DATA_W=32, NUM_REGS=16.
- One sub-module, aux_wb_fifo: synchronous FIFO with push/pop/full/empty/count plus entry-valid and dest vectors for the busy scan.
- The arbiter instantiates it and holds the output register, wait counter and busy logic.

Test Plan:
- Reset: rst=1 for 2 cycles with aux_valid=1 → rf_we=0, busy=0, aux_ready=0, stall_req=0. After rst=0, aux_ready=1.
- Pipeline only: wb_en=1, wb_dest=1, wb_value=0x2 at edge N → after N, rf_we=1, rf_dest=1, rf_value=0x2. After wb_en drops and the FIFO is empty, rf_we=0.
- Aux path: push dest=2, value=0x4 at edge N with wb_en=0 → busy[2]=1 after N; rf_we=1, rf_dest=2, rf_value=0x4 after N+1; busy[2]=0 after N+2.
- Priority and full (DEPTH=4, wb_en held 1):
  - Push 4 aux entries (dest 3,4,5,3; values 0x10..0x13) → aux_ready=0 after the 4th push; busy bits 3,4,5 set; only pipeline data on rf_*.
  - Then drop wb_en → rf_* shows 0x10, 0x11, 0x12, 0x13 on 4 consecutive cycles.
  - busy[3] stays 1 until 0x13 has left the output register.
- Starvation: one queued entry with wb_en=1 for 8 cycles → stall_req=1. After wb_en=0, the pop occurs and stall_req=0 on the next cycle.
- Reset mid-queue: 3 entries queued, pulse rst → FIFO empty, busy=0, rf_we=0, and the discarded entries never appear on rf_*.
